// File: rtl/priority_resolver_n_if.sv
// Bus bundle between the IRR/IMR/OCW front end and the priority resolver.
// The smm signal exists only when SPECIAL_MASK_MODE_EN is defined.
interface priority_resolver_n_if #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned LVL_W   = 3
);
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] imr;
    logic               inta_pulse;
    logic               aeoi;
    logic               rotate_aeoi;
    logic               eoi_valid;
    logic [2:0]         eoi_cmd;
    logic [LVL_W-1:0]   eoi_level;
`ifdef SPECIAL_MASK_MODE_EN
    logic               smm;
`endif
    logic               int_req;
    logic [NUM_IRQ-1:0] irr_clear;
    logic [LVL_W-1:0]   vector_level;
    logic               spurious;
    logic [NUM_IRQ-1:0] isr;
    logic [LVL_W-1:0]   lowest_prio;

    modport master (
`ifdef SPECIAL_MASK_MODE_EN
        output smm,
`endif
        output irr, imr, inta_pulse, aeoi, rotate_aeoi, eoi_valid, eoi_cmd, eoi_level,
        input  int_req, irr_clear, vector_level, spurious, isr, lowest_prio
    );

    modport slave (
`ifdef SPECIAL_MASK_MODE_EN
        input  smm,
`endif
        input  irr, imr, inta_pulse, aeoi, rotate_aeoi, eoi_valid, eoi_cmd, eoi_level,
        output int_req, irr_clear, vector_level, spurious, isr, lowest_prio
    );
endinterface

// File: rtl/priority_resolver_n.sv
// Rotating-priority resolver, INTA handshake and in-service tracker for the PIC core.
// Optional special mask mode is enabled by defining SPECIAL_MASK_MODE_EN.
module priority_resolver_n #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned LVL_W   = 3
) (
    input logic clk,
    input logic reset,
    priority_resolver_n_if.slave bus
);
    typedef enum logic {IDLE, ACK1} state_t;

    typedef struct packed {
        logic             found;
        logic [LVL_W-1:0] lvl;
        logic [LVL_W-1:0] rank;
    } pick_t;

    // Scan from the level just above lowest_prio round to lowest_prio; first hit wins.
    function automatic pick_t pick_top(input logic [NUM_IRQ-1:0] v, input logic [LVL_W-1:0] lp);
        pick_t       r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            idx = lp + k + 1;
            if (idx >= NUM_IRQ) idx -= NUM_IRQ;
            if (!r.found && v[idx[LVL_W-1:0]]) begin
                r.found = 1'b1;
                r.lvl   = idx[LVL_W-1:0];
                r.rank  = k[LVL_W-1:0];
            end
        end
        return r;
    endfunction

    state_t             state_q;
    logic [NUM_IRQ-1:0] isr_q, isr_d, irr_clear_q;
    logic [NUM_IRQ-1:0] masked, nest_src, eoi_clr, aeoi_clr, inta_set;
    logic [LVL_W-1:0]   lp_q, lp_d, vec_q;
    logic               int_req_q, spur_q;
    logic               ack1, ack2, level_ok, int_req_d;
    pick_t              cand, top, top_nest;

    always_comb begin
        masked   = bus.irr & ~bus.imr;
        nest_src = isr_q;
`ifdef SPECIAL_MASK_MODE_EN
        if (bus.smm) nest_src = isr_q & ~bus.imr;
`endif
        cand     = pick_top(masked, lp_q);
        top      = pick_top(isr_q, lp_q);
        top_nest = pick_top(nest_src, lp_q);
        ack1     = bus.inta_pulse && (state_q == IDLE);
        ack2     = bus.inta_pulse && (state_q == ACK1);
        level_ok = 32'(bus.eoi_level) < NUM_IRQ;

        eoi_clr = '0;
        lp_d    = lp_q;
        if (bus.eoi_valid && level_ok) begin
            case (bus.eoi_cmd)
                3'b001: if (top.found) eoi_clr[top.lvl] = 1'b1;
                3'b011: eoi_clr[bus.eoi_level] = 1'b1;
                3'b101: if (top.found) begin
                    eoi_clr[top.lvl] = 1'b1;
                    lp_d             = top.lvl;
                end
                3'b111: begin
                    eoi_clr[bus.eoi_level] = 1'b1;
                    lp_d                   = bus.eoi_level;
                end
                3'b110: lp_d = bus.eoi_level;
                default: ;
            endcase
        end

        // AEOI rotation is assigned last so it overrides a coincident EOI rotation.
        aeoi_clr = '0;
        if (ack2 && bus.aeoi && !spur_q) begin
            aeoi_clr[vec_q] = 1'b1;
            if (bus.rotate_aeoi) lp_d = vec_q;
        end

        inta_set = '0;
        if (ack1 && cand.found) inta_set[cand.lvl] = 1'b1;

        isr_d     = (isr_q & ~eoi_clr & ~aeoi_clr) | inta_set;
        int_req_d = cand.found && (!top_nest.found || (cand.rank < top_nest.rank))
                    && (state_q == IDLE) && !bus.inta_pulse;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            isr_q       <= '0;
            lp_q        <= LVL_W'(NUM_IRQ - 1);
            int_req_q   <= 1'b0;
            irr_clear_q <= '0;
            vec_q       <= '0;
            spur_q      <= 1'b0;
        end else begin
            isr_q       <= isr_d;
            lp_q        <= lp_d;
            int_req_q   <= int_req_d;
            irr_clear_q <= inta_set;
            case (state_q)
                IDLE: if (bus.inta_pulse) begin
                    state_q <= ACK1;
                    if (cand.found) begin
                        vec_q <= cand.lvl;
                    end else begin
                        vec_q  <= LVL_W'(NUM_IRQ - 1);
                        spur_q <= 1'b1;
                    end
                end
                ACK1: if (bus.inta_pulse) begin
                    state_q <= IDLE;
                    spur_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.int_req      = int_req_q;
    assign bus.irr_clear    = irr_clear_q;
    assign bus.vector_level = vec_q;
    assign bus.spurious     = spur_q;
    assign bus.isr          = isr_q;
    assign bus.lowest_prio  = lp_q;
endmodule

// File: tb/tb_priority_resolver_n.sv
// Bench for priority_resolver_n: an 8-line and a 5-line instance share stimulus and are
// checked each cycle against a rank-arithmetic reference model, plus directed scenarios.
module tb_priority_resolver_n;
    localparam int NQ [2] = '{8, 5};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irr_r = '0, imr_r = '0;
    logic       inta_r = 1'b0, aeoi_r = 1'b0, rot_r = 1'b0, eoiv_r = 1'b0;
    logic [2:0] cmd_r = '0, lvl_r = '0;

    always #5 clk = ~clk;

    priority_resolver_n_if #(.NUM_IRQ(8), .LVL_W(3)) if0 ();
    priority_resolver_n_if #(.NUM_IRQ(5), .LVL_W(3)) if1 ();

    assign if0.irr = irr_r;        assign if1.irr = irr_r[4:0];
    assign if0.imr = imr_r;        assign if1.imr = imr_r[4:0];
    assign if0.inta_pulse = inta_r;  assign if1.inta_pulse = inta_r;
    assign if0.aeoi = aeoi_r;        assign if1.aeoi = aeoi_r;
    assign if0.rotate_aeoi = rot_r;  assign if1.rotate_aeoi = rot_r;
    assign if0.eoi_valid = eoiv_r;   assign if1.eoi_valid = eoiv_r;
    assign if0.eoi_cmd = cmd_r;      assign if1.eoi_cmd = cmd_r;
    assign if0.eoi_level = lvl_r;    assign if1.eoi_level = lvl_r;
`ifdef SPECIAL_MASK_MODE_EN
    assign if0.smm = 1'b0;           assign if1.smm = 1'b0;
`endif

    priority_resolver_n #(.NUM_IRQ(8), .LVL_W(3)) u_dut0 (.clk(clk), .reset(rst), .bus(if0));
    priority_resolver_n #(.NUM_IRQ(5), .LVL_W(3)) u_dut1 (.clk(clk), .reset(rst), .bus(if1));

    logic        o_int [2], o_spur [2];
    logic [15:0] o_clr [2], o_isr [2];
    logic [2:0]  o_vec [2], o_lp [2];
    assign o_int[0] = if0.int_req;  assign o_int[1] = if1.int_req;
    assign o_spur[0] = if0.spurious; assign o_spur[1] = if1.spurious;
    assign o_clr[0] = 16'(if0.irr_clear); assign o_clr[1] = 16'(if1.irr_clear);
    assign o_isr[0] = 16'(if0.isr);  assign o_isr[1] = 16'(if1.isr);
    assign o_vec[0] = if0.vector_level; assign o_vec[1] = if1.vector_level;
    assign o_lp[0] = if0.lowest_prio;   assign o_lp[1] = if1.lowest_prio;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: priority expressed as rank distance from lowest_prio.
    bit [15:0] m_isr [2], m_clr [2];
    int        m_lp [2], m_vec [2];
    bit        m_spur [2], m_ack [2], m_int [2];

    function automatic int rank_of(int l, int lp, int n);
        return (l - lp - 1 + 2 * n) % n;
    endfunction

    function automatic int best(bit [15:0] v, int lp, int n);
        int b = -1;
        for (int l = 0; l < n; l++)
            if (v[l] && (b < 0 || rank_of(l, lp, n) < rank_of(b, lp, n))) b = l;
        return b;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_isr[d] = '0; m_clr[d] = '0; m_lp[d] = NQ[d] - 1; m_vec[d] = 0;
            m_spur[d] = 0; m_ack[d] = 0; m_int[d] = 0;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            int n = NQ[d];
            bit [15:0] mask = 16'((1 << n) - 1);
            bit [15:0] masked = 16'(irr_r & ~imr_r) & mask;
            int c = best(masked, m_lp[d], n);
            int t = best(m_isr[d], m_lp[d], n);
            int lvl = int'(lvl_r);
            bit [15:0] nisr = m_isr[d];
            int nlp = m_lp[d];
            if (eoiv_r && lvl < n) begin
                case (cmd_r)
                    3'b001: if (t >= 0) nisr[t] = 1'b0;
                    3'b011: nisr[lvl] = 1'b0;
                    3'b101: if (t >= 0) begin nisr[t] = 1'b0; nlp = t; end
                    3'b111: begin nisr[lvl] = 1'b0; nlp = lvl; end
                    3'b110: nlp = lvl;
                    default: ;
                endcase
            end
            m_clr[d] = '0;
            m_int[d] = 1'b0;
            if (!m_ack[d]) begin
                m_int[d] = (c >= 0) && (t < 0 || rank_of(c, m_lp[d], n) < rank_of(t, m_lp[d], n)) && !inta_r;
                if (inta_r) begin
                    m_ack[d] = 1'b1;
                    if (c >= 0) begin
                        m_vec[d] = c; nisr[c] = 1'b1; m_clr[d][c] = 1'b1;
                    end else begin
                        m_vec[d] = n - 1; m_spur[d] = 1'b1;
                    end
                end
            end else if (inta_r) begin
                m_ack[d] = 1'b0;
                if (aeoi_r && !m_spur[d]) begin
                    nisr[m_vec[d]] = 1'b0;
                    if (rot_r) nlp = m_vec[d];
                end
                m_spur[d] = 1'b0;
            end
            m_isr[d] = nisr;
            m_lp[d]  = nlp;
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d int_req", d), 32'(o_int[d]), 32'(m_int[d]));
            check_eq($sformatf("d%0d irr_clear", d), 32'(o_clr[d]), 32'(m_clr[d]));
            check_eq($sformatf("d%0d vector_level", d), 32'(o_vec[d]), 32'(m_vec[d]));
            check_eq($sformatf("d%0d spurious", d), 32'(o_spur[d]), 32'(m_spur[d]));
            check_eq($sformatf("d%0d isr", d), 32'(o_isr[d]), 32'(m_isr[d]));
            check_eq($sformatf("d%0d lowest_prio", d), 32'(o_lp[d]), 32'(m_lp[d]));
        end
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1 compare_all();
        tick();
        rst = 1'b0;
    endtask

    task automatic eoi(input logic [2:0] cmd, input logic [2:0] lvl);
        eoiv_r = 1'b1; cmd_r = cmd; lvl_r = lvl;
        tick();
        eoiv_r = 1'b0;
    endtask

    task automatic pulse();
        inta_r = 1'b1;
        tick();
        inta_r = 1'b0;
    endtask

    initial begin
        // Reset values and fully nested acknowledge of IR3.
        do_reset();
        check_eq("rst lowest_prio", 32'(o_lp[0]), 32'd7);
        irr_r = 8'h28;
        tick();
        check_eq("t1 int_req", 32'(o_int[0]), 32'd1);
        pulse();
        check_eq("t1 irr_clear", 32'(o_clr[0]), 32'h08);
        irr_r = 8'h20;
        tick();
        check_eq("t1 irr_clear gone", 32'(o_clr[0]), 32'h00);
        pulse();
        check_eq("t1 vector", 32'(o_vec[0]), 32'd3);
        check_eq("t1 isr", 32'(o_isr[0]), 32'h08);

        // Nesting against IR3 in service, then non-specific EOI.
        irr_r = 8'h02;
        tick();
        check_eq("t2 higher int_req", 32'(o_int[0]), 32'd1);
        irr_r = 8'h20;
        tick(); tick();
        check_eq("t2 lower int_req", 32'(o_int[0]), 32'd0);
        eoi(3'b001, 3'd0);
        check_eq("t2 isr cleared", 32'(o_isr[0]), 32'h00);
        tick();
        check_eq("t2 int_req after eoi", 32'(o_int[0]), 32'd1);

        // Automatic EOI with rotation.
        do_reset();
        aeoi_r = 1'b1; rot_r = 1'b1; irr_r = 8'h04;
        tick();
        pulse();
        irr_r = 8'h00;
        tick();
        pulse();
        check_eq("t3 isr", 32'(o_isr[0]), 32'h00);
        check_eq("t3 lowest_prio", 32'(o_lp[0]), 32'd2);
        irr_r = 8'h09;
        tick();
        pulse();
        check_eq("t3 vector", 32'(o_vec[0]), 32'd3);
        irr_r = 8'h00;
        pulse();
        aeoi_r = 1'b0; rot_r = 1'b0;

        // Set priority, including a level beyond the 5-line instance.
        do_reset();
        eoi(3'b110, 3'd5);
        check_eq("t4 lowest_prio", 32'(o_lp[0]), 32'd5);
        check_eq("t4 d1 level out of range", 32'(o_lp[1]), 32'd4);
        irr_r = 8'hC1;
        tick();
        pulse();
        check_eq("t4 vector", 32'(o_vec[0]), 32'd6);
        irr_r = 8'h81;
        pulse();
        eoi(3'b110, 3'd7);
        check_eq("t4 set 7", 32'(o_lp[0]), 32'd7);
        check_eq("t4 d1 unchanged", 32'(o_lp[1]), 32'd4);

        // Spurious acknowledge.
        do_reset();
        irr_r = 8'h10;
        tick();
        irr_r = 8'h00;
        pulse();
        check_eq("t5 spurious", 32'(o_spur[0]), 32'd1);
        check_eq("t5 vector", 32'(o_vec[0]), 32'd7);
        check_eq("t5 isr", 32'(o_isr[0]), 32'h00);
        check_eq("t5 irr_clear", 32'(o_clr[0]), 32'h00);
        pulse();
        check_eq("t5 spurious cleared", 32'(o_spur[0]), 32'd0);

        // Rotating specific EOI coinciding with INTA #1, then reset mid-handshake.
        do_reset();
        irr_r = 8'h10;
        tick();
        pulse();
        irr_r = 8'h00;
        pulse();
        irr_r = 8'h02;
        tick();
        inta_r = 1'b1;
        eoi(3'b111, 3'd4);
        inta_r = 1'b0;
        check_eq("t6 isr", 32'(o_isr[0]), 32'h02);
        check_eq("t6 lowest_prio", 32'(o_lp[0]), 32'd4);
        do_reset();
        check_eq("t6 isr after reset", 32'(o_isr[0]), 32'h00);
        pulse();
        check_eq("t6 lone pulse is INTA1", 32'(o_clr[0]), 32'h02);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            irr_r  = 8'($urandom);
            imr_r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            inta_r = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) aeoi_r = 1'($urandom);
            if ($urandom_range(0, 15) == 0) rot_r = 1'($urandom);
            eoiv_r = ($urandom_range(0, 5) == 0);
            cmd_r  = 3'($urandom);
            if (cmd_r == 3'b001 || cmd_r == 3'b101) lvl_r = 3'($urandom_range(0, 4));
            else lvl_r = 3'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                inta_r = 1'b0; eoiv_r = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
